// File: rtl/pll_pkg.sv
// Shared defaults and width helpers for the pll_div clock-divider stand-in.
package pll_pkg;

  localparam int unsigned PLL_DIV_DEFAULT         = 2;
  localparam int unsigned PLL_LOCK_CYCLES_DEFAULT = 16;

  // Width of a counter that must hold the values 0..lock_cycles.
  function automatic int unsigned lock_cnt_w(input int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  // Width of the half-period counter; never narrower than one bit.
  function automatic int unsigned half_cnt_w(input int unsigned div);
    return (div / 2 > 1) ? $clog2(div / 2) : 1;
  endfunction

  localparam int unsigned LOCK_CNT_W = lock_cnt_w(PLL_LOCK_CYCLES_DEFAULT);

endpackage

// File: rtl/pll_div_if.sv
// Output bundle of pll_div: divided clock plus lock indication.
interface pll_div_if;
  logic c0;
  logic locked;

  modport master (output c0, output locked);
  modport slave  (input c0, input locked);
endinterface

// File: rtl/clk_div_even.sv
// Even integer clock divider: half-period counter driving a toggle flop, gated by en.
module clk_div_even
  import pll_pkg::*;
#(
  parameter int unsigned DIV = PLL_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clk_out
);

  localparam int unsigned Half    = DIV / 2;
  localparam int unsigned HalfW   = half_cnt_w(DIV);
  localparam int unsigned HalfMax = (Half > 0) ? Half - 1 : 0;
  localparam logic [HalfW-1:0] HalfLast = HalfW'(HalfMax);

  logic [HalfW-1:0] half_cnt_q, half_cnt_d;
  logic             clk_q, clk_d;

  always_comb begin
    half_cnt_d = half_cnt_q;
    clk_d      = clk_q;
    if (en) begin
      if (half_cnt_q == HalfLast) begin
        half_cnt_d = '0;
        clk_d      = ~clk_q;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
      end
    end
  end

  // Reset value HalfLast makes the first enabled edge a rising toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt_q <= HalfLast;
      clk_q      <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      clk_q      <= clk_d;
    end
  end

  assign clk_out = clk_q;

endmodule

// File: rtl/pll_div.sv
// Synthesizable PLL stand-in: fixed settle interval before lock, then even division of inclk0.
module pll_div
  import pll_pkg::*;
#(
  parameter int unsigned DIV         = PLL_DIV_DEFAULT,
  parameter int unsigned LOCK_CYCLES = PLL_LOCK_CYCLES_DEFAULT
) (
  input  logic      inclk0,
  input  logic      areset,
  pll_div_if.master pll
);

  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("pll_div: DIV must be even and >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("pll_div: LOCK_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_CYCLES);

  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;
  logic            c0_int;

  // Counter saturates, so locked stays high until the next reset.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (lock_cnt_q != CntMax) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    locked_d = locked_q | (lock_cnt_d == CntMax);
  end

  always_ff @(posedge inclk0) begin
    if (areset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  clk_div_even #(
    .DIV(DIV)
  ) u_clk_div_even (
    .clk     (inclk0),
    .rst     (areset),
    .en      (locked_q),
    .clk_out (c0_int)
  );

  assign pll.c0     = c0_int;
  assign pll.locked = locked_q;

endmodule

// File: tb/tb_pll_div.sv
// Directed bench for pll_div: DIV=2/LOCK=16 and DIV=4/LOCK=5 instances share clock and reset.
module tb_pll_div;

  logic inclk0 = 1'b0;
  logic areset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  pll_div_if if_a ();
  pll_div_if if_b ();

  pll_div #(
    .DIV         (2),
    .LOCK_CYCLES (16)
  ) u_dut_a (
    .inclk0 (inclk0),
    .areset (areset),
    .pll    (if_a)
  );

  pll_div #(
    .DIV         (4),
    .LOCK_CYCLES (5)
  ) u_dut_b (
    .inclk0 (inclk0),
    .areset (areset),
    .pll    (if_b)
  );

  always #5 inclk0 = ~inclk0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  // Edges numbered from 1 after reset release; expected values hand-derived per instance:
  // A locks at 16, c0 high on odd edges from 17; B locks at 5, c0 high on edges 6,7,10,11,...
  task automatic lock_seq(input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      check("a_locked", int'(if_a.locked), int'(e >= 16));
      check("a_c0", int'(if_a.c0), int'(e >= 17 && ((e - 17) % 2) == 0));
      check("b_locked", int'(if_b.locked), int'(e >= 5));
      check("b_c0", int'(if_b.c0), int'(e >= 6 && ((e - 6) % 4) < 2));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_c0"}, int'(if_a.c0), 0);
    check({tag, "_a_locked"}, int'(if_a.locked), 0);
    check({tag, "_b_c0"}, int'(if_b.c0), 0);
    check({tag, "_b_locked"}, int'(if_b.locked), 0);
  endtask

  initial begin
    int   rises;
    int   highs;
    int   drops;
    int   last_rise;
    int   k;
    logic prev;

    // Power-up reset for 3 edges.
    repeat (3) begin
      tick();
      check_all_zero("rst");
    end
    areset = 1'b0;
    lock_seq(40);

    // Steady state on A: edges 41..240 give 100 full periods of 2 cycles.
    rises     = 0;
    highs     = 0;
    drops     = 0;
    last_rise = 0;
    prev      = if_a.c0;
    for (int e = 41; e <= 240; e++) begin
      tick();
      if (if_a.c0 && !prev) begin
        if (rises > 0) check("a_period", e - last_rise, 2);
        last_rise = e;
        rises++;
      end
      if (if_a.c0) highs++;
      if (!if_a.locked) drops++;
      prev = if_a.c0;
    end
    check("a_rises", rises, 100);
    check("a_highs", highs, 100);
    check("a_lock_drops", drops, 0);

    // Mid-operation reset while A's c0 is high.
    k = 0;
    while (!if_a.c0 && k < 4) begin
      tick();
      k++;
    end
    check("a_c0_pre_rst", int'(if_a.c0), 1);
    areset = 1'b1;
    tick();
    check_all_zero("mid_rst");
    areset = 1'b0;
    lock_seq(24);

    // Long reset: nothing advances, then a full lock sequence from edge 1.
    areset = 1'b1;
    repeat (40) begin
      tick();
      check_all_zero("long_rst");
    end
    areset = 1'b0;
    lock_seq(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
